// File: rtl/decode_pipe.sv
// decode_pipe: RV32 decode stage with register file, WB bypass, load-use stall and ID/EX register.
// Optional macro DECODE_M_EXT_EN decodes funct7=0000001 R-type as M-extension instead of illegal.
module decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_alu_in1,
  output logic [XLEN-1:0] ex_alu_in2,
  output logic [4:0]      ex_alu_op,
  output logic [PC_W-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic            ex_dmem_en,
  output logic            ex_dmem_we,
  output logic            ex_rd_we,
  output logic [4:0]      ex_rd_addr,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic            ex_illegal,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      op;
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs2_data;
    logic            dmem_en;
    logic            dmem_we;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            illegal;
    logic            in2_rs2;
  } idex_t;
  idex_t q, d;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic is_r, is_i, is_ld, is_st, is_br, is_jalr, is_jal, is_auipc, is_lui, is_m, is_shift;
  logic known, m_bad, rs1_used, rs2_used, rd_used, illegal, hazard, accept, wb_ok;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm, rd1, rd2;
  function automatic logic in_range(input logic [4:0] a);
    return {1'b0, a} < NR;
  endfunction
  assign opc = if_instr[6:0];
  assign f3  = if_instr[14:12];
  assign f7  = if_instr[31:25];
  assign rd  = if_instr[11:7];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jalr  = opc == 7'b1100111;
  assign is_jal   = opc == 7'b1101111;
  assign is_auipc = opc == 7'b0010111;
  assign is_lui   = opc == 7'b0110111;
  assign is_m     = is_r && f7 == 7'b0000001;
  assign is_shift = is_i && f3[1:0] == 2'b01;
  assign known    = is_r | is_i | is_ld | is_st | is_br | is_jalr | is_jal | is_auipc | is_lui;
  assign rs1_used = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign rs2_used = is_r | is_st | is_br;
  assign rd_used  = is_r | is_i | is_ld | is_jalr | is_jal | is_auipc | is_lui;
`ifdef DECODE_M_EXT_EN
  assign m_bad = 1'b0;
`else
  assign m_bad = is_m;
`endif
  assign illegal = ~known | m_bad | (rs1_used & ~in_range(rs1)) | (rs2_used & ~in_range(rs2)) |
                   (rd_used & ~in_range(rd));
  assign imm32 = is_st ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
                 is_br ? {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0} :
                 (is_lui | is_auipc) ? {if_instr[31:12], 12'b0} :
                 is_jal ? {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0} :
                 is_r ? 32'sd0 : {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm   = XLEN'(imm32);
  assign wb_ok = wb_we && wb_addr != 5'd0 && in_range(wb_addr);
  // Same-cycle WB bypass; x0 and out-of-range indices read as zero
  assign rd1 = (rs1 == 5'd0 || !in_range(rs1)) ? '0 : (wb_ok && wb_addr == rs1) ? wb_data : regs[rs1[AW-1:0]];
  assign rd2 = (rs2 == 5'd0 || !in_range(rs2)) ? '0 : (wb_ok && wb_addr == rs2) ? wb_data : regs[rs2[AW-1:0]];
  assign hazard = q.valid & q.dmem_en & ~q.dmem_we & q.rd_addr != 5'd0 &
                  ((rs1_used & rs1 == q.rd_addr) | (rs2_used & rs2 == q.rd_addr));
  assign if_ready = ~flush & ~hazard & (~q.valid | ex_ready);
  assign accept   = if_valid & if_ready;
  always_comb begin
    d          = '0;
    d.valid    = 1'b1;
    d.in1      = is_lui ? imm : (is_jal | is_auipc) ? XLEN'(if_pc) : rd1;
    d.in2      = is_lui ? '0 : (is_r | is_br) ? rd2 : is_shift ? XLEN'(rs2) : imm;
    d.op       = is_m ? {2'b10, f3} : (is_r | is_shift) ? {1'b0, f7[5], f3} : is_i ? {2'b00, f3} : 5'd0;
    d.pc       = if_pc;
    d.opcode   = opc;
    d.funct3   = f3;
    d.imm      = imm;
    d.rs2_data = rs2_used ? rd2 : '0;
    d.dmem_en  = (is_ld | is_st) & ~illegal;
    d.dmem_we  = is_st & ~illegal;
    d.rd_we    = rd_used & ~illegal;
    d.rd_addr  = d.rd_we ? rd : 5'd0;
    d.rs1_addr = rs1_used ? rs1 : 5'd0;
    d.rs2_addr = rs2_used ? rs2 : 5'd0;
    d.illegal  = illegal;
    d.in2_rs2  = is_r | is_br;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end
  // While EX stalls, late WB results refresh the held register operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (flush) q <= '0;
    else if (accept) q <= d;
    else if (q.valid && !ex_ready) begin
      if (wb_ok && wb_addr == q.rs1_addr) q.in1 <= wb_data;
      if (wb_ok && wb_addr == q.rs2_addr) begin
        q.rs2_data <= wb_data;
        if (q.in2_rs2) q.in2 <= wb_data;
      end
    end else q <= '0;
  end
  assign ex_valid    = q.valid;
  assign ex_alu_in1  = q.in1;
  assign ex_alu_in2  = q.in2;
  assign ex_alu_op   = q.op;
  assign ex_pc       = q.pc;
  assign ex_opcode   = q.opcode;
  assign ex_funct3   = q.funct3;
  assign ex_imm      = q.imm;
  assign ex_rs2_data = q.rs2_data;
  assign ex_dmem_en  = q.dmem_en;
  assign ex_dmem_we  = q.dmem_we;
  assign ex_rd_we    = q.rd_we;
  assign ex_rd_addr  = q.rd_addr;
  assign ex_rs1_addr = q.rs1_addr;
  assign ex_rs2_addr = q.rs2_addr;
  assign ex_illegal  = q.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed checks of decode_pipe (RV32I instance plus a NUM_REGS=16 instance).
module tb_decode_pipe;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, if_valid = 1'b0, ex_ready = 1'b1, wb_we = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, wb_data = '0;
  logic [4:0] wb_addr = '0;
  logic if_ready, ex_valid, ex_dmem_en, ex_dmem_we, ex_rd_we, ex_illegal;
  logic [31:0] ex_alu_in1, ex_alu_in2, ex_pc, ex_imm, ex_rs2_data;
  logic [4:0] ex_alu_op, ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
  logic s_if_ready, s_ex_valid, s_dmem_en, s_dmem_we, s_rd_we, s_illegal;
  logic [31:0] s_in1, s_in2, s_pc, s_imm, s_rs2_data;
  logic [4:0] s_op, s_rd_addr, s_rs1_addr, s_rs2_addr;
  logic [6:0] s_opcode;
  logic [2:0] s_funct3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  decode_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_alu_op(ex_alu_op), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data),
    .ex_dmem_en(ex_dmem_en), .ex_dmem_we(ex_dmem_we), .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_illegal(ex_illegal),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );
  decode_pipe #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(s_if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .ex_valid(s_ex_valid), .ex_ready(ex_ready),
    .ex_alu_in1(s_in1), .ex_alu_in2(s_in2), .ex_alu_op(s_op), .ex_pc(s_pc),
    .ex_opcode(s_opcode), .ex_funct3(s_funct3), .ex_imm(s_imm), .ex_rs2_data(s_rs2_data),
    .ex_dmem_en(s_dmem_en), .ex_dmem_we(s_dmem_we), .ex_rd_we(s_rd_we), .ex_rd_addr(s_rd_addr),
    .ex_rs1_addr(s_rs1_addr), .ex_rs2_addr(s_rs2_addr), .ex_illegal(s_illegal),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc = pc;
    #1;
  endtask
  initial begin
    #3;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_in1", ex_alu_in1, 32'd0);
    chk("rst_rd_we", 32'(ex_rd_we), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    #9 rst = 1'b1;
    offer(32'h002088B3, 32'h0);
    chk("rv32e_if_ready", 32'(s_if_ready), 32'd1);
    tick;
    chk("rv32e_illegal", 32'(s_illegal), 32'd1);
    chk("rv32e_rd_we", 32'(s_rd_we), 32'd0);
    chk("rv32e_valid", 32'(s_ex_valid), 32'd1);
    chk("rv32i_x17_rd", 32'(ex_rd_addr), 32'd17);
    chk("rv32i_x17_legal", 32'(ex_illegal), 32'd0);
    offer(32'h00500093, 32'h4);
    tick;
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_in1", ex_alu_in1, 32'd0);
    chk("addi_in2", ex_alu_in2, 32'd5);
    chk("addi_op", 32'(ex_alu_op), 32'd0);
    chk("addi_rd", 32'(ex_rd_addr), 32'd1);
    chk("addi_rd_we", 32'(ex_rd_we), 32'd1);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    offer(32'h00318233, 32'h8);
    tick;
    wb_we = 1'b0;
    chk("bypass_in1", ex_alu_in1, 32'hDEAD);
    chk("bypass_in2", ex_alu_in2, 32'hDEAD);
    offer(32'h0000A283, 32'hC);
    tick;
    chk("lw_dmem_en", 32'(ex_dmem_en), 32'd1);
    chk("lw_dmem_we", 32'(ex_dmem_we), 32'd0);
    offer(32'h00228333, 32'h10);
    chk("hazard_if_ready", 32'(if_ready), 32'd0);
    tick;
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_rd_we", 32'(ex_rd_we), 32'd0);
    chk("after_bubble_if_ready", 32'(if_ready), 32'd1);
    tick;
    chk("add_after_load_valid", 32'(ex_valid), 32'd1);
    chk("add_after_load_rd", 32'(ex_rd_addr), 32'd6);
    offer(32'h00712223, 32'h14);
    tick;
    chk("sw_dmem_we", 32'(ex_dmem_we), 32'd1);
    chk("sw_rs2_addr", 32'(ex_rs2_addr), 32'd7);
    chk("sw_rd_addr", 32'(ex_rd_addr), 32'd0);
    chk("sw_rs2_data0", ex_rs2_data, 32'd0);
    ex_ready = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    offer(32'h00500093, 32'h18);
    chk("hold_if_ready0", 32'(if_ready), 32'd0);
    tick;
    wb_we = 1'b0;
    chk("hold_rs2_data", ex_rs2_data, 32'h55);
    chk("hold_in2_imm", ex_alu_in2, 32'd4);
    chk("hold_if_ready1", 32'(if_ready), 32'd0);
    tick;
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_if_ready2", 32'(if_ready), 32'd0);
    tick;
    chk("hold_rs2_data_kept", ex_rs2_data, 32'h55);
    ex_ready = 1'b1;
    #1;
    chk("release_if_ready", 32'(if_ready), 32'd1);
    tick;
    chk("release_rd", 32'(ex_rd_addr), 32'd1);
    chk("release_dmem_en", 32'(ex_dmem_en), 32'd0);
    flush = 1'b1;
    offer(32'h12345137, 32'h1C);
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    tick;
    flush = 1'b0;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rd_we", 32'(ex_rd_we), 32'd0);
    tick;
    chk("lui_in1", ex_alu_in1, 32'h12345000);
    chk("lui_in2", ex_alu_in2, 32'd0);
    chk("lui_rd", 32'(ex_rd_addr), 32'd2);
    offer(32'h00338433, 32'h20);
    tick;
    chk("rf_in1_x7", ex_alu_in1, 32'h55);
    chk("rf_in2_x3", ex_alu_in2, 32'hDEAD);
    offer(32'h40315093, 32'h24);
    tick;
    chk("srai_in2", ex_alu_in2, 32'd3);
    chk("srai_op", 32'(ex_alu_op), 32'h0D);
    offer(32'h008000EF, 32'h100);
    tick;
    chk("jal_in1", ex_alu_in1, 32'h100);
    chk("jal_in2", ex_alu_in2, 32'd8);
    chk("jal_rd_we", 32'(ex_rd_we), 32'd1);
    offer(32'h0000007F, 32'h104);
    tick;
    chk("badop_illegal", 32'(ex_illegal), 32'd1);
    chk("badop_rd_we", 32'(ex_rd_we), 32'd0);
    chk("badop_valid", 32'(ex_valid), 32'd1);
    offer(32'h023100B3, 32'h108);
    tick;
`ifdef DECODE_M_EXT_EN
    chk("mul_op", 32'(ex_alu_op), 32'h10);
    chk("mul_illegal", 32'(ex_illegal), 32'd0);
    chk("mul_rd_we", 32'(ex_rd_we), 32'd1);
`else
    chk("mul_illegal", 32'(ex_illegal), 32'd1);
    chk("mul_rd_we", 32'(ex_rd_we), 32'd0);
`endif
    if_valid = 1'b0;
    tick;
    chk("idle_valid", 32'(ex_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Parametrised RV32 decode stage with a valid/ready handshake on both sides, an internal register file and an ID/EX output register.
- Reads operands, applying same-cycle WB bypass.
- Generates ALU and memory/WB controls.
- Detects load-use hazards and inserts one bubble.
- Refreshes held operands while EX back-pressures.
- Sits between fetch and execute; successor to the fixed-width, handshake-less decode stage.

Parameters:
XLEN, 32, datapath and register width
NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E); address width is clog2(NUM_REGS)
PC_W, 32, program-counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of ID/EX contents and of the current IF offer
if_valid  in  1  fetch offers instr/pc
if_ready  out  1  decode accepts this cycle
if_instr  in  32  instruction
if_pc  in  PC_W  instruction PC
ex_valid  out  1  ID/EX register holds a live instruction
ex_ready  in  1  EX consumes this cycle
ex_alu_in1  out  XLEN  ALU operand 1
ex_alu_in2  out  XLEN  ALU operand 2
ex_alu_op  out  5  {mext, funct7[5], funct3}
ex_pc  out  PC_W  PC of held instruction
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_imm  out  XLEN  sign-extended immediate
ex_rs2_data  out  XLEN  store data or branch operand
ex_dmem_en  out  1  memory access
ex_dmem_we  out  1  store
ex_rd_we  out  1  writes rd
ex_rd_addr  out  5  rd
ex_rs1_addr  out  5  rs1 (0 if unused)
ex_rs2_addr  out  5  rs2 (0 if unused)
ex_illegal  out  1  undecodable instruction
wb_we  in  1  register-file write
wb_addr  in  5  write address
wb_data  in  XLEN  write data

Behaviour:
Reset (rst=0, asynchronous):
- All ex_* outputs are 0 and ex_valid=0.
- All register-file entries are 0.
- if_ready reflects combinational state: 1 once out of reset.

Handshake:
- hazard = ex_valid & ex_dmem_en & ~ex_dmem_we & ex_rd_addr!=0 & (rd==rs1 with rs1 used, or rd==rs2 with rs2 used).
- if_ready = ~flush & ~hazard & (~ex_valid | ex_ready).
- Accept when if_valid & if_ready: ID/EX loads the decoded fields and ex_valid=1; latency is 1 cycle.
- If ex_ready=1 but no accept (bubble or hazard): ex_valid<=0 and all control fields go to 0.
- If ex_valid & ~ex_ready: all fields hold.
- flush has priority over everything: ex_valid<=0 and controls go to 0 next cycle.

Register file:
- Writes are ignored when wb_addr=0 or wb_addr>=NUM_REGS.
- Reads of x0 return 0.
- Bypass: if wb_we, wb_addr==rs and rs!=0, the read returns wb_data.

Hold refresh:
- While holding, if wb_we and wb_addr matches a used, nonzero ex_rs1_addr/ex_rs2_addr, the corresponding ex_alu_in1/ex_alu_in2/ex_rs2_data is updated to wb_data.

Decode (alu_op defaults to add = 0):
- R-type: in1=rs1, in2=rs2, op={0,f7[5],f3}, rd_we=1.
- I-arith:
  - Shifts (f3=001/101): in2=zero-extended shamt, op={0,f7[5],f3}.
  - Others: in2=imm, op={0,0,f3}.
  - rs2 unused.
- Load: in1=rs1, in2=imm, dmem_en=1, rd_we=1.
- Store: in1=rs1, in2=imm, dmem_en=1, dmem_we=1, rd_we=0.
- Branch: in1=rs1, in2=rs2, rd_we=0.
- JALR: in1=rs1, in2=imm, rd_we=1.
- JAL and AUIPC: in1=pc, in2=imm, rd_we=1.
- LUI: in1=imm, in2=0, rd_we=1.
- ex_rd_addr=0 whenever rd_we=0.

Illegal:
- Triggers: unknown opcode, or any used register index >= NUM_REGS.
- Response: ex_illegal=1, rd_we=0, dmem_en=0, ex_valid=1, so EX traps.

Optional Feature:
DECODE_M_EXT_EN
- Defined: R-type with funct7=0000001 decodes as M-extension; op={1,0,f3}, rd_we=1.
- Undefined: the same encoding sets ex_illegal=1 and rd_we=0.

Test Plan:
- Reset, then ADDI x1,x0,5 with ex_ready=1 -> next cycle ex_valid=1, alu_in1=0, alu_in2=5, alu_op=0, rd_addr=1, rd_we=1.
- WB writes x3=0xDEAD in the same cycle ADD x4,x3,x3 is accepted -> ex_alu_in1 = ex_alu_in2 = 0xDEAD.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> if_ready=0 for 1 cycle, one bubble (ex_valid=0), then ADD is accepted.
- ex_ready=0 for 3 cycles holding SW x7,4(x2) while WB writes x7=0x55 -> ex_rs2_data=0x55 and if_ready=0 throughout.
- flush asserted with a live instruction and if_valid=1 -> next cycle ex_valid=0, ex_rd_we=0, fetch not accepted.
- NUM_REGS=16, ADD x17,x1,x2 -> ex_illegal=1, ex_rd_we=0. With the macro, MUL x1,x2,x3 gives alu_op=5'b10000; without it, ex_illegal=1.
